// File: rtl/adaptive_traffic_controller.sv
// Demand-actuated four-phase intersection controller with green extension,
// phase skipping and emergency preemption.
module adaptive_traffic_controller #(
  parameter int TIMER_W   = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       preempt,
  output logic [1:0] N_forward,
  output logic [1:0] N_left,
  output logic [1:0] S_forward,
  output logic [1:0] S_left,
  output logic [1:0] E_forward,
  output logic [1:0] E_left,
  output logic [1:0] W_forward,
  output logic [1:0] W_left,
  output logic [1:0] cur_phase,
  output logic       preempt_active
);

  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [TIMER_W-1:0] GMIN_LAST = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_LAST = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AR_LAST   = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         demand_q, demand_d;

  logic [3:0] phase_onehot;
  logic       other_demand;
  logic [7:0] demand_dbl;
  logic [3:0] demand_rot;
  logic [1:0] next_phase;
  logic       green_done;

  assign phase_onehot = 4'b0001 << phase_q;
  assign other_demand = |(demand_q & ~phase_onehot);

  // demand_rot[k] is the demand of phase (phase_q + 1 + k) mod 4, so the
  // lowest set bit is the first phase met when scanning round-robin.
  assign demand_dbl = {demand_q, demand_q};
  assign demand_rot = demand_dbl[{1'b0, phase_q} + 3'd1 +: 4];

  always_comb begin
    next_phase = 2'd0;
    if (demand_rot[0])      next_phase = phase_q + 2'd1;
    else if (demand_rot[1]) next_phase = phase_q + 2'd2;
    else if (demand_rot[2]) next_phase = phase_q + 2'd3;
    else if (demand_rot[3]) next_phase = phase_q;
  end

  // Phase 0 only yields at GREEN_MIN when someone else is waiting; other
  // phases yield as soon as their own sensor goes quiet.
  assign green_done = preempt
                   || ((timer_q >= GMIN_LAST) && !req[phase_q]
                       && ((phase_q != 2'd0) || other_demand))
                   || ((timer_q == GMAX_LAST) && other_demand);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    timer_d  = timer_q + TIMER_ONE;
    demand_d = demand_q | req;
    case (state_q)
      S_GREEN: begin
        if (green_done) begin
          state_d = S_YELLOW;
          timer_d = '0;
        end else if (timer_q == GMAX_LAST) begin
          timer_d = timer_q;
        end
      end
      S_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = S_ALLRED;
          timer_d = '0;
        end
      end
      S_ALLRED: begin
        if (timer_q == AR_LAST) begin
          timer_d = '0;
          if (preempt) begin
            state_d = S_HOLD;
          end else begin
            state_d              = S_GREEN;
            phase_d              = next_phase;
            demand_d[next_phase] = 1'b0;
          end
        end
      end
      S_HOLD: begin
        timer_d = '0;
        if (!preempt) state_d = S_ALLRED;
      end
      default: begin
        state_d = S_ALLRED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_ALLRED;
      phase_q  <= 2'd3;
      timer_q  <= '0;
      demand_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      demand_q <= demand_d;
    end
  end

  logic [1:0] lamp;

  always_comb begin
    lamp = (state_q == S_GREEN)  ? 2'b10 :
           (state_q == S_YELLOW) ? 2'b01 : 2'b00;
    N_forward = 2'b00;
    S_forward = 2'b00;
    E_forward = 2'b00;
    W_forward = 2'b00;
    N_left    = 2'b00;
    S_left    = 2'b00;
    E_left    = 2'b00;
    W_left    = 2'b00;
    case (phase_q)
      2'd0: begin N_forward = lamp; S_forward = lamp; end
      2'd1: begin E_forward = lamp; W_forward = lamp; end
      2'd2: begin N_left    = lamp; S_left    = lamp; end
      default: begin E_left = lamp; W_left    = lamp; end
    endcase
  end

  assign cur_phase      = phase_q;
  assign preempt_active = (state_q == S_HOLD);

endmodule

// File: tb/tb_adaptive_traffic_controller.sv
// Scoreboard bench: per-cycle expected head/phase values are queued with the
// stimulus, then replayed and compared at each falling edge.
module tb_adaptive_traffic_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] N_forward, N_left, S_forward, S_left;
  logic [1:0] E_forward, E_left, W_forward, W_left;
  logic [1:0] cur_phase;
  logic       preempt_active;

  adaptive_traffic_controller dut (
    .clk(clk), .reset(reset), .req(req), .preempt(preempt),
    .N_forward(N_forward), .N_left(N_left), .S_forward(S_forward), .S_left(S_left),
    .E_forward(E_forward), .E_left(E_left), .W_forward(W_forward), .W_left(W_left),
    .cur_phase(cur_phase), .preempt_active(preempt_active)
  );

  always #5 clk = ~clk;

  localparam int K_G = 0;
  localparam int K_Y = 1;
  localparam int K_R = 2;
  localparam int K_H = 3;

  int checks = 0;
  int errors = 0;
  string scen;

  logic [18:0] obs;
  assign obs = {N_forward, N_left, S_forward, S_left,
                E_forward, E_left, W_forward, W_left, cur_phase, preempt_active};

  logic [18:0] exp_q[$];
  logic [3:0]  req_q[$];
  logic        pre_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [18:0] exp_obs(input int kind, input int ph);
    logic [15:0] l;
    logic [1:0]  code;
    l = '0;
    code = (kind == K_G) ? 2'b10 : (kind == K_Y) ? 2'b01 : 2'b00;
    case (ph)
      0: begin l[15:14] = code; l[11:10] = code; end
      1: begin l[7:6]   = code; l[3:2]   = code; end
      2: begin l[13:12] = code; l[9:8]   = code; end
      default: begin l[5:4] = code; l[1:0] = code; end
    endcase
    return {l, 2'(ph), (kind == K_H)};
  endfunction

  function automatic logic [1:0] phase_lamp(input int ph);
    case (ph)
      0: return N_forward | S_forward;
      1: return E_forward | W_forward;
      2: return N_left | S_left;
      default: return E_left | W_left;
    endcase
  endfunction

  task automatic plan(input int kind, input int ph, input int n, input logic [3:0] r, input logic p);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_obs(kind, ph));
      req_q.push_back(r);
      pre_q.push_back(p);
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      chk(scen, 32'(obs), 32'(exp_q.pop_front()));
      req     = req_q.pop_front();
      preempt = pre_q.pop_front();
      @(negedge clk);
    end
    $display("scenario %s done, checks so far %0d", scen, checks);
  endtask

  // Phase 1 green with req[1] held for `hold` green cycles and demand[0] pending.
  task automatic ext(input int hold, input int len);
    plan(K_G, 0, 2, 4'b0010, 1'b0);
    plan(K_Y, 0, 1, 4'b0011, 1'b0);
    plan(K_Y, 0, 1, 4'b0010, 1'b0);
    plan(K_R, 0, 1, 4'b0010, 1'b0);
    for (int i = 0; i < len; i++)
      plan(K_G, 1, 1, (i < hold) ? 4'b0010 : 4'b0000, 1'b0);
    plan(K_Y, 1, 2, 4'b0, 1'b0);
    plan(K_R, 1, 1, 4'b0, 1'b0);
    plan(K_G, 0, 4, 4'b0, 1'b0);
    plan(K_Y, 0, 2, 4'b0, 1'b0);
    plan(K_R, 0, 1, 4'b0, 1'b0);
    plan(K_G, 1, 4, 4'b0, 1'b0);
    plan(K_Y, 1, 2, 4'b0, 1'b0);
    plan(K_R, 1, 1, 4'b0, 1'b0);
    plan(K_G, 0, 5, 4'b0, 1'b0);
    drain();
  endtask

  initial begin
    int prev_green;
    int lit;
    int green_ph;
    reset   = 1'b1;
    req     = 4'b0;
    preempt = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_heads", 32'(obs[18:3]), 32'd0);
    chk("reset_phase", 32'(cur_phase), 32'd3);
    chk("reset_pa", 32'(preempt_active), 32'd0);
    reset = 1'b0;

    scen = "rest";
    plan(K_R, 3, 1, 4'b0, 1'b0);
    plan(K_G, 0, 100, 4'b0, 1'b0);
    drain();

    scen = "pulse_ew";
    plan(K_G, 0, 1, 4'b0010, 1'b0);
    plan(K_G, 0, 1, 4'b0, 1'b0);
    plan(K_Y, 0, 2, 4'b0, 1'b0);
    plan(K_R, 0, 1, 4'b0, 1'b0);
    plan(K_G, 1, 4, 4'b0, 1'b0);
    plan(K_Y, 1, 2, 4'b0, 1'b0);
    plan(K_R, 1, 1, 4'b0, 1'b0);
    plan(K_G, 0, 5, 4'b0, 1'b0);
    drain();

    scen = "skip";
    plan(K_G, 0, 1, 4'b1000, 1'b0);
    plan(K_G, 0, 1, 4'b0, 1'b0);
    plan(K_Y, 0, 2, 4'b0, 1'b0);
    plan(K_R, 0, 1, 4'b0, 1'b0);
    plan(K_G, 3, 4, 4'b0, 1'b0);
    plan(K_Y, 3, 2, 4'b0, 1'b0);
    plan(K_R, 3, 1, 4'b0, 1'b0);
    plan(K_G, 0, 5, 4'b0, 1'b0);
    drain();

    scen = "extend_max";
    ext(8, 8);
    scen = "extend_rel5";
    ext(5, 6);

    scen = "preempt";
    plan(K_G, 0, 1, 4'b0100, 1'b0);
    plan(K_G, 0, 1, 4'b0, 1'b0);
    plan(K_Y, 0, 2, 4'b0, 1'b0);
    plan(K_R, 0, 1, 4'b0, 1'b0);
    plan(K_G, 2, 1, 4'b0, 1'b0);
    plan(K_G, 2, 1, 4'b0, 1'b1);
    plan(K_Y, 2, 2, 4'b0, 1'b1);
    plan(K_R, 2, 1, 4'b0, 1'b1);
    plan(K_H, 2, 1, 4'b1000, 1'b1);
    plan(K_H, 2, 3, 4'b0, 1'b1);
    plan(K_H, 2, 1, 4'b0, 1'b0);
    plan(K_R, 2, 1, 4'b0, 1'b0);
    plan(K_G, 3, 4, 4'b0, 1'b0);
    plan(K_Y, 3, 2, 4'b0, 1'b0);
    plan(K_R, 3, 1, 4'b0, 1'b0);
    plan(K_G, 0, 5, 4'b0, 1'b0);
    drain();

    scen = "pre_reset";
    plan(K_G, 0, 1, 4'b0010, 1'b0);
    plan(K_G, 0, 1, 4'b0100, 1'b0);
    drain();
    chk("yellow_before_reset", 32'(obs), 32'(exp_obs(K_Y, 0)));
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(obs), 32'(exp_obs(K_R, 3)));
    @(negedge clk);
    reset = 1'b0;
    scen = "post_reset";
    plan(K_R, 3, 1, 4'b0, 1'b0);
    plan(K_G, 0, 20, 4'b0, 1'b0);
    drain();

    prev_green = -1;
    for (int c = 0; c < 12000; c++) begin
      lit = 0;
      green_ph = -1;
      for (int p = 0; p < 4; p++) begin
        if (phase_lamp(p) != 2'b00) lit++;
        if (phase_lamp(p) == 2'b10) green_ph = p;
      end
      chk("one_phase_lit", 32'(lit <= 1), 32'd1);
      if (prev_green >= 0 && green_ph != prev_green)
        chk("green_to_yellow", 32'(phase_lamp(prev_green)), 32'd1);
      prev_green = green_ph;
      req = 4'($urandom & $urandom);
      if ($urandom_range(0, 49) == 0) preempt = ~preempt;
      @(negedge clk);
    end
    $display("scenario random done, checks so far %0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
